// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
//   Lets two requesters share one combinational signed WIDTH x WIDTH multiplier.
//   One request is accepted at a time, with a round-robin choice between the two.
//   The operands are registered and held on the multiplier inputs for LATENCY
//   cycles, so the multiplier can be timed as a multicycle path. The block then
//   captures {product, ovr} and returns it on a tagged valid/ready response port.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req{0,1}_valid/ready/a/b   requester handshake and operands (ready is combinational)
//   mult_1, mult_2             registered operands driven to the multiplier
//   product, ovr               multiplier result and overflow flag
//   resp_valid/ready           response handshake
//   resp_id                    requester that owns the response
//   resp_product, resp_ovr     captured multiplier result
//   busy                       high while an operation is in flight or waiting to be taken
//
// LATENCY legal range: 1..15. The hold counter is 4 bits wide.

module mult_share_ctrl #(
   parameter int WIDTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [WIDTH-1:0]   req0_a,
   input  logic [WIDTH-1:0]   req0_b,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [WIDTH-1:0]   req1_a,
   input  logic [WIDTH-1:0]   req1_b,
   output logic [WIDTH-1:0]   mult_1,
   output logic [WIDTH-1:0]   mult_2,
   input  logic [2*WIDTH-1:0] product,
   input  logic               ovr,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic               resp_id,
   output logic [2*WIDTH-1:0] resp_product,
   output logic               resp_ovr,
   output logic               busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [1:0]         state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               last_grant_q, last_grant_d;
   logic [WIDTH-1:0]   mult_1_q, mult_1_d;
   logic [WIDTH-1:0]   mult_2_q, mult_2_d;
   logic               resp_id_q, resp_id_d;
   logic [2*WIDTH-1:0] resp_product_q, resp_product_d;
   logic               resp_ovr_q, resp_ovr_d;

   logic               grant;   // 0 = requester 0, 1 = requester 1
   logic               accept;

   // Arbitration. A request is only offered in IDLE. On a tie, the requester
   // that did not win last time gets the grant. No state is kept for a
   // requester that loses and then drops valid.
   always_comb begin
      grant      = 1'b0;
      accept     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (state_q == ST_IDLE) begin
         if (req0_valid && req1_valid) grant = ~last_grant_q;
         else                          grant = req1_valid;
         accept     = req0_valid | req1_valid;
         req0_ready = accept & ~grant;
         req1_ready = accept &  grant;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      last_grant_d   = last_grant_q;
      mult_1_d       = mult_1_q;
      mult_2_d       = mult_2_q;
      resp_id_d      = resp_id_q;
      resp_product_d = resp_product_q;
      resp_ovr_d     = resp_ovr_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               mult_1_d     = grant ? req1_a : req0_a;
               mult_2_d     = grant ? req1_b : req0_b;
               resp_id_d    = grant;
               last_grant_d = grant;
               cnt_d        = CNT_INIT;
               state_d      = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // The operands have been stable for LATENCY cycles once cnt reaches 0.
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               resp_product_d = product;
               resp_ovr_d     = ovr;
               state_d        = ST_DONE;
            end
         end
         ST_DONE: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= 4'd0;
         last_grant_q   <= 1'b1;
         mult_1_q       <= '0;
         mult_2_q       <= '0;
         resp_id_q      <= 1'b0;
         resp_product_q <= '0;
         resp_ovr_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         last_grant_q   <= last_grant_d;
         mult_1_q       <= mult_1_d;
         mult_2_q       <= mult_2_d;
         resp_id_q      <= resp_id_d;
         resp_product_q <= resp_product_d;
         resp_ovr_q     <= resp_ovr_d;
      end
   end

   assign mult_1       = mult_1_q;
   assign mult_2       = mult_2_q;
   assign resp_id      = resp_id_q;
   assign resp_product = resp_product_q;
   assign resp_ovr     = resp_ovr_q;
   assign resp_valid   = (state_q == ST_DONE);
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl. It contains a behavioural signed
// multiplier model, a LATENCY=2 instance and a LATENCY=1 instance. The two
// instances share the request inputs, reset and resp_ready.
module tb_mult_share_ctrl;
   localparam int W = 64;

   localparam logic [127:0] P_M15  = {{64{1'b1}}, 64'hFFFF_FFFF_FFFF_FFF1};
   localparam logic [127:0] P_M20  = {{64{1'b1}}, 64'hFFFF_FFFF_FFFF_FFEC};
   localparam logic [127:0] P_2E64 = 128'h1_0000_0000_0000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset;
   logic           req0_valid, req1_valid, resp_ready;
   logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
   logic           req0_ready, req1_ready, resp_valid, resp_id, resp_ovr, busy, ovr;
   logic [W-1:0]   mult_1, mult_2;
   logic [2*W-1:0] product, resp_product;

   logic           l1_req0_ready, l1_req1_ready, l1_resp_valid, l1_resp_id, l1_resp_ovr, l1_busy, l1_ovr;
   logic [W-1:0]   l1_mult_1, l1_mult_2;
   logic [2*W-1:0] l1_product, l1_resp_product;

   // Signed multiplier. ovr is set when the product does not fit in W signed bits.
   function automatic logic [2*W:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      return {~((&p[2*W-1:W-1]) | ~(|p[2*W-1:W-1])), p};
   endfunction

   assign {ovr, product}       = mul(mult_1, mult_2);
   assign {l1_ovr, l1_product} = mul(l1_mult_1, l1_mult_2);

   mult_share_ctrl #(.WIDTH(W), .LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .mult_1(mult_1), .mult_2(mult_2), .product(product), .ovr(ovr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_product(resp_product), .resp_ovr(resp_ovr), .busy(busy)
   );

   mult_share_ctrl #(.WIDTH(W), .LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(l1_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(l1_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .mult_1(l1_mult_1), .mult_2(l1_mult_2), .product(l1_product), .ovr(l1_ovr),
      .resp_valid(l1_resp_valid), .resp_ready(resp_ready), .resp_id(l1_resp_id),
      .resp_product(l1_resp_product), .resp_ovr(l1_resp_ovr), .busy(l1_busy)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Stimulus is applied 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
   endtask

   // Counts cycles after the accept edge until resp_valid is high. Returns 99 on timeout.
   task automatic wait_resp(output int cyc);
      cyc = 1;
      while (!resp_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      if (!resp_valid) cyc = 99;
   endtask

   task automatic take_resp();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   typedef struct {
      logic         sel;
      logic [63:0]  a;
      logic [63:0]  b;
      logic [127:0] exp_p;
      logic         exp_ovr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int cyc, lat0, lat1, nacc, nresp;
      int acc_cyc[4];
      logic acc_g[4];
      logic rv_seen;

      vecs[0] = '{1'b0, 64'd3, -64'sd5, P_M15, 1'b0};
      vecs[1] = '{1'b1, 64'd7, 64'd6, 128'd42, 1'b0};
      vecs[2] = '{1'b0, -64'sd1, -64'sd1, 128'd1, 1'b0};
      vecs[3] = '{1'b1, 64'h4000_0000_0000_0000, 64'd4, P_2E64, 1'b1};
      vecs[4] = '{1'b0, 64'h8000_0000_0000_0000, -64'sd1, 128'h8000_0000_0000_0000, 1'b1};
      vecs[5] = '{1'b1, 64'h1_0000_0000, 64'h7FFF_FFFF, 128'h7FFF_FFFF_0000_0000, 1'b0};

      idle_inputs();
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mult_1", mult_1, 0);
      chk("rst_mult_2", mult_2, 0);
      chk("rst_resp_product", resp_product, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_ovr", resp_ovr, 0);

      // Single-request vectors: latency, operand passthrough and result.
      foreach (vecs[i]) begin
         if (vecs[i].sel) begin
            req1_valid = 1'b1; req1_a = vecs[i].a; req1_b = vecs[i].b;
         end else begin
            req0_valid = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b;
         end
         #1;
         chk($sformatf("v%0d_ready_sel", i), vecs[i].sel ? req1_ready : req0_ready, 1);
         chk($sformatf("v%0d_ready_oth", i), vecs[i].sel ? req0_ready : req1_ready, 0);
         tick();
         req0_valid = 1'b0; req1_valid = 1'b0;
         wait_resp(cyc);
         chk($sformatf("v%0d_latency", i), cyc, 3);
         chk($sformatf("v%0d_mult_1", i), mult_1, vecs[i].a);
         chk($sformatf("v%0d_mult_2", i), mult_2, vecs[i].b);
         chk($sformatf("v%0d_resp_id", i), resp_id, vecs[i].sel);
         chk($sformatf("v%0d_product", i), resp_product, vecs[i].exp_p);
         chk($sformatf("v%0d_ovr", i), resp_ovr, vecs[i].exp_ovr);
         take_resp();
         chk($sformatf("v%0d_idle", i), busy, 0);
      end

      // Both requesters held valid: grants alternate and issue every 4 cycles.
      req0_a = 64'd2;   req0_b = 64'd3;
      req1_a = -64'sd4; req1_b = 64'd5;
      req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
      nacc = 0; nresp = 0;
      for (int c = 0; c < 40 && nresp < 4; c++) begin
         #1;
         if (resp_valid) begin
            chk("rr_resp_id", resp_id, nresp[0]);
            chk("rr_product", resp_product, nresp[0] ? P_M20 : 128'd6);
            chk("rr_no_ready_in_done", req0_ready | req1_ready, 0);
            nresp++;
         end
         if ((req0_ready | req1_ready) && nacc < 4) begin
            acc_g[nacc] = req1_ready;
            acc_cyc[nacc] = c;
            nacc++;
         end
         tick();
      end
      idle_inputs();
      chk("rr_accepts", nacc, 4);
      for (int i = 0; i < 4 && i < nacc; i++) begin
         chk($sformatf("rr_grant%0d", i), acc_g[i], i[0]);
         chk($sformatf("rr_interval%0d", i), acc_cyc[i] - acc_cyc[0], 4 * i);
      end

      // Response stall: outputs held in DONE, no accept until the handshake is done.
      req0_valid = 1'b1; req0_a = 64'd11; req0_b = 64'd13;
      tick();
      req0_valid = 1'b0;
      wait_resp(cyc);
      chk("stall_latency", cyc, 3);
      req1_valid = 1'b1; req1_a = 64'd1; req1_b = 64'd1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("stall_resp_valid", resp_valid, 1);
         chk("stall_product", resp_product, 128'd143);
         chk("stall_readies", {req0_ready, req1_ready}, 0);
         tick();
      end
      take_resp();
      #1;
      chk("stall_release_idle", busy, 0);
      chk("stall_new_accept", req1_ready, 1);
      tick();
      req1_valid = 1'b0;
      wait_resp(cyc);
      chk("stall_next_id", resp_id, 1);
      chk("stall_next_product", resp_product, 128'd1);
      take_resp();

      // Operand hold: changing the requester's data during WAIT has no effect.
      req0_valid = 1'b1; req0_a = 64'd5; req0_b = 64'd9;
      tick();
      req0_valid = 1'b0; req0_a = 64'd99; req0_b = 64'd77;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("hold_mult_1", mult_1, 64'd5);
         chk("hold_mult_2", mult_2, 64'd9);
         tick();
      end
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_product", resp_product, 128'd45);
      take_resp();

      // Reset during WAIT: the operation is dropped and the arbiter restarts
      // with req0 winning a tie.
      req0_valid = 1'b1; req0_a = 64'd8; req0_b = 64'd8;
      tick();
      req0_valid = 1'b0;
      chk("rw_in_wait", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rw_resp_valid", resp_valid, 0);
      chk("rw_busy", busy, 0);
      chk("rw_mult_1", mult_1, 0);
      chk("rw_mult_2", mult_2, 0);
      chk("rw_resp_id", resp_id, 0);
      chk("rw_resp_product", resp_product, 0);
      chk("rw_resp_ovr", resp_ovr, 0);
      rv_seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (resp_valid) rv_seen = 1'b1;
         tick();
      end
      chk("rw_no_response", rv_seen, 0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("rw_tie_req0", req0_ready, 1);
      chk("rw_tie_req1", req1_ready, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Overflow passthrough on both instances; LATENCY=1 responds a cycle earlier.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req0_valid = 1'b1; req0_a = 64'h4000_0000_0000_0000; req0_b = 64'd4;
      #1;
      chk("ovr_accept_l2", req0_ready, 1);
      chk("ovr_accept_l1", l1_req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      lat0 = 99; lat1 = 99;
      for (int c = 1; c < 20 && (lat0 == 99 || lat1 == 99); c++) begin
         if (resp_valid && lat0 == 99) lat0 = c;
         if (l1_resp_valid && lat1 == 99) lat1 = c;
         tick();
      end
      chk("ovr_latency_l2", lat0, 3);
      chk("ovr_latency_l1", lat1, 2);
      chk("ovr_flag_l2", resp_ovr, 1);
      chk("ovr_flag_l1", l1_resp_ovr, 1);
      chk("ovr_product_l2", resp_product, P_2E64);
      chk("ovr_product_l1", l1_resp_product, P_2E64);
      chk("ovr_id_l1", l1_resp_id, 0);
      take_resp();
      chk("ovr_idle_l1", l1_busy | l1_req1_ready, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

endmodule
